// File: rtl/y86_pkg.sv
// y86_pkg: shared types and constants for the y86 boot memory slice
package y86_pkg;
  localparam int BUS_W = 32;
  localparam logic [BUS_W-1:0] CON_ADDR_DEF = 32'hFFFF_FF00;
  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN} state_t;
endpackage

// File: rtl/y86_bytemem.sv
// y86_bytemem: byte array with loader port plus wrapping little-endian 32-bit bus ports
module y86_bytemem
  import y86_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [7:0]        i_ld_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BUS_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [BUS_W-1:0]  o_rdata
);
  logic [7:0] r_mem [2**ADDR_W];
  // byte offsets add in ADDR_W bits so accesses wrap at the top of memory
  always_ff @(posedge clk) begin
    if (i_ld_we) r_mem[i_ld_addr] <= i_ld_data;
    if (i_we)
      for (int k = 0; k < BUS_W / 8; k++)
        r_mem[i_addr + ADDR_W'(k)] <= i_wdata[8*k +: 8];
  end
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < BUS_W / 8; k++)
      o_rdata[8*k +: 8] = r_mem[i_raddr + ADDR_W'(k)];
  end
endmodule

// File: rtl/y86_boot_mem.sv
// y86_boot_mem: boot loader FSM, console register and run counter around the byte memory
module y86_boot_mem
  import y86_pkg::*;
#(
  parameter int              ADDR_W      = 12,
  parameter int              HOLD_CYCLES = 4,
  parameter logic [BUS_W-1:0] CON_ADDR   = CON_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_rst,
  input  logic [BUS_W-1:0]  bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [BUS_W-1:0]  bus_out,
  output logic [BUS_W-1:0]  bus_in,
  output logic              con_valid,
  output logic [7:0]        con_data,
  output logic [31:0]       run_cycles
);
  state_t            r_state;
  logic [ADDR_W:0]   r_ld_count;
  logic              r_ld_err;
  logic              r_cpu_rst;
  logic [7:0]        r_hold;
  logic              r_con_valid;
  logic [7:0]        r_con_data;
  logic [31:0]       r_run_cycles;
  logic              w_run;
  logic              w_xfer;
  logic              w_room;
  logic              w_con_hit;
  logic              w_con;
  logic              w_mem_we;
  logic [BUS_W-1:0]  w_rdata;

  assign w_run     = r_state == S_RUN;
  assign ld_ready  = r_state == S_LOAD;
  assign w_xfer    = ld_valid && ld_ready;
  // count saturates at exactly 2^ADDR_W, so the top bit alone means full
  assign w_room    = !r_ld_count[ADDR_W];
  assign w_con_hit = bus_A == CON_ADDR;
  assign w_con     = w_run && bus_WE && w_con_hit;
  assign w_mem_we  = w_run && bus_WE && !w_con_hit;
  assign bus_in    = (w_run && bus_RE) ? w_rdata : '0;

  assign ld_count   = r_ld_count;
  assign ld_err     = r_ld_err;
  assign cpu_rst    = r_cpu_rst;
  assign con_valid  = r_con_valid;
  assign con_data   = r_con_data;
  assign run_cycles = r_run_cycles;

  y86_bytemem #(.ADDR_W(ADDR_W)) u_mem (
    .clk      (clk),
    .i_ld_we  (w_xfer && w_room),
    .i_ld_addr(r_ld_count[ADDR_W-1:0]),
    .i_ld_data(ld_data),
    .i_we     (w_mem_we),
    .i_addr   (bus_A[ADDR_W-1:0]),
    .i_wdata  (bus_out),
    .i_raddr  (bus_A[ADDR_W-1:0]),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOAD;
      r_ld_count   <= '0;
      r_ld_err     <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_hold       <= '0;
      r_con_valid  <= 1'b0;
      r_con_data   <= '0;
      r_run_cycles <= '0;
    end else begin
      r_con_valid <= w_con;
      if (w_con) r_con_data <= bus_out[7:0];
      case (r_state)
        S_LOAD: if (w_xfer) begin
          if (w_room) r_ld_count <= r_ld_count + 1'b1;
          else r_ld_err <= 1'b1;
          if (ld_last) begin
            r_state <= S_HOLD;
            r_hold  <= 8'(HOLD_CYCLES - 1);
          end
        end
        S_HOLD: if (r_hold == '0) begin
          r_state   <= S_RUN;
          r_cpu_rst <= 1'b0;
        end else r_hold <= r_hold - 1'b1;
        S_RUN: r_run_cycles <= r_run_cycles + 1'b1;
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_y86_boot_mem.sv
// tb_y86_boot_mem: directed self-checking bench for the boot loader and bus memory
module tb_y86_boot_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_err;
  logic [12:0] ld_count;
  logic        cpu_rst;
  logic [31:0] bus_A = '0;
  logic        bus_RE = 1'b0;
  logic        bus_WE = 1'b0;
  logic [31:0] bus_out = '0;
  logic [31:0] bus_in;
  logic        con_valid;
  logic [7:0]  con_data;
  logic [31:0] run_cycles;
  int checks = 0;
  int errors = 0;

  y86_boot_mem dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_err(ld_err), .ld_count(ld_count), .cpu_rst(cpu_rst),
    .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE), .bus_out(bus_out), .bus_in(bus_in),
    .con_valid(con_valid), .con_data(con_data), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_A  = a;
    bus_RE = 1'b1;
    #1;
    chk(tag, bus_in, exp);
    bus_RE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_A   = a;
    bus_out = d;
    bus_WE  = 1'b1;
    tick();
    bus_WE  = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_con_data", 32'(con_data), 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    rd("rst_bus_in", 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    send(8'h8B, 1'b0);
    send(8'h4D, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_count", 32'(ld_count), 32'd2);
    chk("stall_ready", 32'(ld_ready), 32'd1);
    chk("stall_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h01, 1'b0);
    send(8'hF4, 1'b1);
    chk("load_count", 32'(ld_count), 32'd4);
    chk("hold_ready", 32'(ld_ready), 32'd0);
    chk("hold_cpu_rst0", 32'(cpu_rst), 32'd1);
    rd("hold_bus_in", 32'd0, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("hold_cpu_rst%0d", i), 32'(cpu_rst), 32'd1);
    end
    tick();
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_cycles0", run_cycles, 32'd0);
    tick();
    chk("run_cycles1", run_cycles, 32'd1);
    rd("rd_boot", 32'd0, 32'hF4014D8B);
    rd("rd_alias", 32'h0000_1000, 32'hF4014D8B);
    rd("rd_re0_gate", 32'd0, 32'hF4014D8B);
    bus_A = 32'd0;
    #1;
    chk("re_low_bus_in", bus_in, 32'd0);
    wr(32'h0000_0FFE, 32'hDEADBEEF);
    rd("rd_wrap", 32'h0000_0FFE, 32'hDEADBEEF);
    rd("rd_low_after_wrap", 32'd0, 32'hF401DEAD);
    bus_A = 32'd0;
    bus_out = 32'h11223344;
    bus_RE = 1'b1;
    bus_WE = 1'b1;
    #1;
    chk("rw_pre_write", bus_in, 32'hF401DEAD);
    tick();
    bus_WE = 1'b0;
    bus_RE = 1'b0;
    rd("rw_post_write", 32'd0, 32'h11223344);
    wr(32'h0000_0F00, 32'hCAFEF00D);
    wr(32'hFFFF_FF00, 32'h0000_0041);
    chk("con_pulse", 32'(con_valid), 32'd1);
    chk("con_data", 32'(con_data), 32'h41);
    tick();
    chk("con_pulse_end", 32'(con_valid), 32'd0);
    chk("con_data_hold", 32'(con_data), 32'h41);
    rd("con_mem_kept", 32'h0000_0F00, 32'hCAFEF00D);
    rst = 1'b0;
    #1;
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_run", run_cycles, 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_count", 32'(ld_count), 32'd0);
    rst = 1'b1;
    tick();
    send(8'h77, 1'b1);
    chk("reload_count", 32'(ld_count), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("reload_run", 32'(cpu_rst), 32'd0);
    rd("reload_keep_f00", 32'h0000_0F00, 32'hCAFEF00D);
    rd("reload_byte0", 32'd0, 32'h11223377);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4096; i++) send(8'(i), 1'b0);
    chk("full_count", 32'(ld_count), 32'd4096);
    chk("full_no_err", 32'(ld_err), 32'd0);
    send(8'hAA, 1'b1);
    chk("ovf_count", 32'(ld_count), 32'd4096);
    chk("ovf_err", 32'(ld_err), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_run", 32'(cpu_rst), 32'd0);
    rd("ovf_rd_10", 32'h0000_0010, 32'h13121110);
    rd("ovf_rd_wrap", 32'h0000_0FFE, 32'h0100FFFE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
